sobel_frame_streamer: RTL and testbench

Reads one SIZE x SIZE greyscale frame from a synchronous-read frame memory and transmits it, in raster order, as a valid/ready pixel stream. This stream is the input the sobel filter receives. The block is the transmit end of the pixel-stream interface the filter consumes. It marks start-of-frame, end-of-line and end-of-frame on each beat and absorbs downstream backpressure without losing or duplicating pixels.

---
 rtl/sobel_pkg.sv | 11 +
 rtl/sobel_skid_fifo.sv | 31 +++
 rtl/sobel_frame_streamer.sv | 91 +++++++++
 tb/tb_sobel_frame_streamer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types for the sobel pixel-stream transmit path.
package sobel_pkg;
   localparam int DEF_PIX_W = 8;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef struct packed {
      logic [DEF_PIX_W-1:0] data;
      logic                 sof;
      logic                 eol;
      logic                 eof;
   } pixel_beat_t;
endpackage

// File: rtl/sobel_skid_fifo.sv
// sobel_skid_fifo: two-entry beat buffer between frame-memory returns and the stream port.
module sobel_skid_fifo
   import sobel_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  pixel_beat_t din,
   output logic [1:0]  count,
   output pixel_beat_t head
);
   pixel_beat_t mem [2];
   logic        wp, rp;
   assign head = mem[rp];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp      <= ~wp;
         end
         if (pop) rp <= ~rp;
         count <= count + 2'(push) - 2'(pop);
      end
endmodule

// File: rtl/sobel_frame_streamer.sv
// sobel_frame_streamer: reads a SIZE x SIZE frame from synchronous memory and
// streams it in raster order with sof/eol/eof marks under valid/ready backpressure.
module sobel_frame_streamer
   import sobel_pkg::*;
#(
   parameter int SIZE   = 100,
   parameter int PIX_W  = DEF_PIX_W,
   parameter int ADDR_W = $clog2(SIZE*SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [PIX_W-1:0]  m_data,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_eof
);
   localparam int CW = $clog2(SIZE);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE*SIZE-1);
   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [CW-1:0]     row, col;
   logic              inflight, f_sof, f_eol, f_eof, pop, last_col;
   logic [1:0]        count;
   pixel_beat_t       din, head;
   assign pop      = m_valid & m_ready;
   assign mem_addr = addr;
   assign last_col = col == CW'(SIZE-1);
   assign din      = '{data: mem_rdata, sof: f_sof, eol: f_eol, eof: f_eof};
   assign m_valid  = count != 2'd0;
   assign m_data   = head.data;
   assign m_sof    = m_valid & head.sof;
   assign m_eol    = m_valid & head.eol;
   assign m_eof    = m_valid & head.eof;
   sobel_skid_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .pop   (pop),
      .din   (din),
      .count (count),
      .head  (head)
   );
   // Credit rule: buffered + in-flight beats, net of this cycle's pop, never exceed two.
   always_comb begin
      state_nx = state;
      mem_en   = 1'b0;
      busy     = state == RUN || state == DRAIN;
      done     = state == DONE;
      if (state == IDLE && start) state_nx = RUN;
      if (state == RUN) begin
         mem_en = int'(count) + int'(inflight) - int'(pop) < 2;
         if (mem_en && addr == LAST) state_nx = DRAIN;
      end
      if (state == DRAIN && count == {1'b0, pop} && !inflight) state_nx = DONE;
      if (state == DONE) state_nx = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         addr     <= '0;
         row      <= '0;
         col      <= '0;
         inflight <= 1'b0;
         f_sof    <= 1'b0;
         f_eol    <= 1'b0;
         f_eof    <= 1'b0;
      end else begin
         state    <= state_nx;
         inflight <= mem_en;
         if (state == IDLE && start) begin
            addr <= '0;
            row  <= '0;
            col  <= '0;
         end else if (mem_en) begin
            addr  <= addr + ADDR_W'(1);
            f_sof <= row == '0 && col == '0;
            f_eol <= last_col;
            f_eof <= last_col && row == CW'(SIZE-1);
            col   <= last_col ? '0 : col + CW'(1);
            row   <= last_col ? row + CW'(1) : row;
         end
      end
endmodule

// File: tb/tb_sobel_frame_streamer.sv
// tb_sobel_frame_streamer: table-driven checks on a 4x4 instance plus a randomized-ready 100x100 scoreboard run.
module tb_sobel_frame_streamer;
   typedef struct {
      logic [7:0] data;
      logic [2:0] f;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic        start4 = 1'b0, rdy4 = 1'b0, busy4, done4, en4, v4, sof4, eol4, eof4;
   logic [3:0]  addr4;
   logic [7:0]  rd4, d4;
   logic        start100 = 1'b0, rdy100 = 1'b0, busy100, done100, en100, v100, sof100, eol100, eof100;
   logic [13:0] addr100;
   logic [7:0]  rd100, d100;
   sobel_frame_streamer #(.SIZE(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
      .mem_en(en4), .mem_addr(addr4), .mem_rdata(rd4),
      .m_valid(v4), .m_ready(rdy4), .m_data(d4), .m_sof(sof4), .m_eol(eol4), .m_eof(eof4)
   );
   sobel_frame_streamer #(.SIZE(100)) dut100 (
      .clk(clk), .rst(rst), .start(start100), .busy(busy100), .done(done100),
      .mem_en(en100), .mem_addr(addr100), .mem_rdata(rd100),
      .m_valid(v100), .m_ready(rdy100), .m_data(d100), .m_sof(sof100), .m_eol(eol100), .m_eof(eof100)
   );
   always_ff @(posedge clk) if (en4) rd4 <= 8'(addr4);
   always_ff @(posedge clk) if (en100) rd100 <= addr100[7:0];
   int   total = 0, bad = 0;
   vec_t tbl [16];
   vec_t got [$];
   int   got_cyc [$];
   int   first_v, done_cyc, done_n, max_out, unstable, busy1, busy_done;
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   // Streams one 4x4 frame; ready is low on cycles lo..hi; ghost adds start pulses while busy and on done.
   task automatic run4(input int lo, input int hi, input bit ghost);
      int   issued = 0, acc = 0;
      logic ps = 1'b0;
      vec_t pv;
      got.delete();
      got_cyc.delete();
      first_v = -1; done_cyc = -1; done_n = 0; max_out = 0; unstable = 0; busy1 = 0; busy_done = -1;
      @(negedge clk);
      start4 = 1'b1;
      rdy4   = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start4 = ghost && c == 6;
         rdy4   = !(c >= lo && c <= hi);
         #1;
         if (c == 1) busy1 = busy4;
         if (ps && (!v4 || d4 !== pv.data || {sof4, eol4, eof4} !== pv.f)) unstable++;
         if (v4 && first_v < 0) first_v = c;
         if (en4) issued++;
         if (v4 && rdy4) begin
            got.push_back('{d4, {sof4, eol4, eof4}});
            got_cyc.push_back(c);
            acc++;
         end
         if (issued - acc > max_out) max_out = issued - acc;
         ps = v4 && !rdy4;
         pv = '{d4, {sof4, eol4, eof4}};
         if (done4) begin
            done_n++;
            if (done_cyc < 0) begin
               done_cyc  = c;
               busy_done = busy4;
            end
            if (ghost) start4 = 1'b1;
         end
      end
      start4 = 1'b0;
   endtask
   task automatic cmp4(input string nm, input int exp_done);
      chk({nm, " beats"}, got.size(), 16);
      for (int i = 0; i < 16 && i < got.size(); i++) begin
         chk($sformatf("%s data[%0d]", nm, i), got[i].data, tbl[i].data);
         chk($sformatf("%s sof_eol_eof[%0d]", nm, i), got[i].f, tbl[i].f);
      end
      chk({nm, " first_valid_cycle"}, first_v, 3);
      chk({nm, " done_pulses"}, done_n, 1);
      chk({nm, " done_cycle"}, done_cyc, exp_done);
      if (got.size() > 0) chk({nm, " done_after_last_beat"}, done_cyc - got_cyc[got.size()-1], 1);
      chk({nm, " busy_after_start"}, busy1, 1);
      chk({nm, " busy_at_done"}, busy_done, 0);
      chk({nm, " outstanding_le_2"}, int'(max_out <= 2), 1);
      chk({nm, " stall_stability_errors"}, unstable, 0);
   endtask
   initial begin
      int   n, errs, eols, eofs, found, seen, cnt_v, cnt_d;
      tbl = '{'{8'd0, 3'b100}, '{8'd1, 3'b000}, '{8'd2, 3'b000}, '{8'd3, 3'b010},
              '{8'd4, 3'b000}, '{8'd5, 3'b000}, '{8'd6, 3'b000}, '{8'd7, 3'b010},
              '{8'd8, 3'b000}, '{8'd9, 3'b000}, '{8'd10, 3'b000}, '{8'd11, 3'b010},
              '{8'd12, 3'b000}, '{8'd13, 3'b000}, '{8'd14, 3'b000}, '{8'd15, 3'b011}};
      #12;
      chk("reset ctrl {busy,done,mem_en,valid}", {busy4, done4, en4, v4}, 0);
      chk("reset flags", {sof4, eol4, eof4}, 0);
      chk("reset mem_addr", addr4, 0);
      chk("reset m_data", d4, 0);
      chk("reset dut100 valid_busy", {v100, busy100, en100}, 0);
      @(negedge clk);
      rst = 1'b0;
      run4(99, 99, 1'b0);
      cmp4("frame4", 19);
      run4(8, 12, 1'b0);
      cmp4("stall4", 24);
      run4(99, 99, 1'b1);
      cmp4("ghost4", 19);
      run4(99, 99, 1'b0);
      cmp4("second4", 19);
      @(negedge clk);
      start4 = 1'b1;
      rdy4   = 1'b1;
      found  = 0;
      for (int c = 1; c <= 30 && found == 0; c++) begin
         @(negedge clk);
         start4 = 1'b0;
         #1;
         if (v4 && d4 == 8'd7) found = 1;
      end
      chk("midrst reached beat7", found, 1);
      rst = 1'b1;
      #1;
      chk("midrst ctrl {busy,done,mem_en,valid}", {busy4, done4, en4, v4}, 0);
      chk("midrst flags", {sof4, eol4, eof4}, 0);
      chk("midrst mem_addr_data", {addr4, d4}, 0);
      @(negedge clk);
      rst   = 1'b0;
      cnt_v = 0;
      cnt_d = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         cnt_v += int'(v4);
         cnt_d += int'(done4);
      end
      chk("postrst idle valid", cnt_v, 0);
      chk("postrst no done", cnt_d, 0);
      run4(99, 99, 1'b0);
      cmp4("restart4", 19);
      @(negedge clk);
      start100 = 1'b1;
      rdy100   = 1'b1;
      n = 0; errs = 0; eols = 0; eofs = 0; seen = 0;
      for (int c = 1; c <= 50000 && seen == 0; c++) begin
         @(negedge clk);
         start100 = 1'b0;
         rdy100   = 1'($urandom_range(0, 1));
         #1;
         if (v100 && rdy100) begin
            if (d100 !== n[7:0] || sof100 !== (n == 0) || eol100 !== (n % 100 == 99) || eof100 !== (n == 9999))
               errs++;
            eols += int'(eol100);
            eofs += int'(eof100);
            n++;
         end
         if (done100) seen = 1;
      end
      chk("rand100 done seen", seen, 1);
      chk("rand100 beats", n, 10000);
      chk("rand100 beat errors", errs, 0);
      chk("rand100 eol count", eols, 100);
      chk("rand100 eof count", eofs, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
